// File: rtl/bcd_scan_display.sv
// Multi-digit BCD up/down counter with a time-multiplexed, active-low seven-segment driver.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is always shown).
module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_RESET = ~(DIGITS'(1));

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                carry_q, carry_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic [4*DIGITS-1:0] step_val;
  logic                step_wrap;
  logic [4*DIGITS-1:0] load_clean;
  logic [3:0]          sel_dig;
  logic                sel_blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h01;
      4'd1:    decode = 7'h4F;
      4'd2:    decode = 7'h12;
      4'd3:    decode = 7'h06;
      4'd4:    decode = 7'h4C;
      4'd5:    decode = 7'h24;
      4'd6:    decode = 7'h20;
      4'd7:    decode = 7'h0F;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h04;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Ripple decimal step: the chain stays set while every lower digit wrapped.
  always_comb begin
    logic chain;
    logic [3:0] dig;
    step_val = bcd_q;
    chain    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      dig = bcd_q[4*k +: 4];
      if (chain) begin
        if (up) begin
          if (dig == 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = dig + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = dig - 4'd1;
            chain = 1'b0;
          end
        end
      end
    end
    step_wrap = chain;
  end

  always_comb begin
    load_clean = '0;
    for (int k = 0; k < DIGITS; k++) begin
      load_clean[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
    end
  end

  always_comb begin
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    if (load) begin
      bcd_d = load_clean;
    end else if (en) begin
      bcd_d   = step_val;
      carry_d = step_wrap;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_mask;

  // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic acc;
    blank_mask = '0;
    acc        = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      acc           = acc && (bcd_q[4*k +: 4] == 4'd0);
      blank_mask[k] = acc && (k != 0);
    end
  end
`endif

  // Outputs follow the next index so every digit is lit for a full dwell.
  always_comb begin
    sel_dig   = '0;
    sel_blank = 1'b0;
    an_d      = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx_d) begin
        sel_dig = bcd_q[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        sel_blank = blank_mask[k];
`endif
        an_d[k] = 1'b0;
      end
    end
    seg_d = sel_blank ? 7'h7F : decode(sel_dig);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_q   <= '0;
      carry_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= 7'h01;
      an_q    <= AN_RESET;
    end else begin
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bcd   = bcd_q;
  assign carry = carry_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed and random checks of bcd_scan_display against a decimal reference model and scoreboard.
module tb_bcd_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] bcd;
  logic        carry;
  logic [6:0]  seg;
  logic [3:0]  an;

  typedef struct {
    logic [15:0] bcd;
    logic        carry;
    logic [6:0]  seg;
    logic [3:0]  an;
  } exp_t;

  exp_t exp_q[$];
  int   m_val;
  int   m_presc;
  int   m_idx;
  int   tests_run;
  int   tests_failed;

  bcd_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .up(up),
    .load(load),
    .load_val(load_val),
    .bcd(bcd),
    .carry(carry),
    .seg(seg),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clean_val(input logic [15:0] lv);
    int v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v = v * 10 + ((lv[4*k +: 4] > 4'd9) ? 0 : int'(lv[4*k +: 4]));
    end
    return v;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    return tbl[d];
  endfunction

  // Drive one cycle of inputs and push what the DUT must show after the next edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u, input logic l,
                               input logic [15:0] lv);
    exp_t x;
    int   old_val;
    rst_n    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    old_val  = m_val;
    x.carry  = 1'b0;
    if (!r) begin
      m_val   = 0;
      m_presc = 0;
      m_idx   = 0;
    end else begin
      if (l) begin
        m_val = clean_val(lv);
      end else if (e) begin
        if (u) begin
          if (m_val == MAXV) begin m_val = 0; x.carry = 1'b1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MAXV; x.carry = 1'b1; end
          else m_val = m_val - 1;
        end
      end
      if (m_presc == SCAN_DIV - 1) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % DIGITS;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    x.bcd = to_bcd(m_val);
    x.an  = ~(4'b0001 << m_idx);
    if (!r) begin
      x.seg = 7'h01;
    end else begin
      x.seg = seg_of((old_val / pow10(m_idx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx > 0 && (old_val / pow10(m_idx)) == 0) x.seg = 7'h7F;
`endif
    end
    exp_q.push_back(x);
  endtask

  task automatic checkOutput(input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s scoreboard empty", tag);
      return;
    end
    x = exp_q.pop_front();
    tests_run++;
    assert (bcd === x.bcd) else begin
      tests_failed++;
      $error("[TB] FAIL %s bcd got %h expected %h", tag, bcd, x.bcd);
    end
    tests_run++;
    assert (carry === x.carry) else begin
      tests_failed++;
      $error("[TB] FAIL %s carry got %b expected %b", tag, carry, x.carry);
    end
    tests_run++;
    assert (seg === x.seg) else begin
      tests_failed++;
      $error("[TB] FAIL %s seg got %h expected %h", tag, seg, x.seg);
    end
    tests_run++;
    assert (an === x.an) else begin
      tests_failed++;
      $error("[TB] FAIL %s an got %b expected %b", tag, an, x.an);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [15:0] lv, input string tag);
    applyStimulus(r, e, u, l, lv);
    checkOutput(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_val        = 0;
    m_presc      = 0;
    m_idx        = 0;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    step(0, 0, 1, 0, 16'h0000, "reset0");
    step(0, 0, 1, 0, 16'h0000, "reset1");

    for (int i = 0; i < 18; i++) step(1, 0, 1, 0, 16'h0000, "scan_idle");

    step(1, 0, 1, 1, 16'h0998, "load_0998");
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 16'h0000, "count_up");
    step(1, 0, 1, 0, 16'h0000, "hold_1001");

    step(1, 0, 1, 1, 16'h9999, "load_9999");
    step(1, 1, 1, 0, 16'h0000, "wrap_up");
    step(1, 0, 1, 0, 16'h0000, "carry_clear");
    step(1, 1, 0, 0, 16'h0000, "wrap_down");
    step(1, 0, 0, 0, 16'h0000, "carry_clear2");

    step(1, 0, 1, 1, 16'hA5F3, "load_clean");
    for (int i = 0; i < 16; i++) step(1, 0, 1, 0, 16'h0000, "lz_frame");

    step(1, 0, 1, 1, 16'h0042, "load_0042");
    step(1, 1, 1, 1, 16'h0007, "load_beats_en");
    step(1, 0, 1, 0, 16'h0000, "hold_0007");

    for (int i = 0; i < 40 && !(m_idx == 2 && m_presc == 1); i++)
      step(1, 1, 1, 0, 16'h0000, "count_to_d2");
    step(0, 1, 1, 0, 16'h0000, "mid_reset");
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 16'h0000, "post_reset");

    step(1, 0, 1, 1, 16'h0095, "load_0095");
    for (int i = 0; i < 12; i++) step(1, (i % 2) == 0, 1, 0, 16'h0000, "toggle_up");
    for (int i = 0; i < 12; i++) step(1, (i % 2) == 1, 0, 0, 16'h0000, "toggle_down");

    for (int i = 0; i < 80; i++) begin
      logic [15:0] rv;
      rv = 16'($urandom);
      step(1, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), rv, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
